// File: rtl/load_queue_unit.sv
// Load queue: DEPTH-entry FIFO of issued loads, req/ack memory access, CDB writeback and RS tag match.
// Optional LOAD_SUBWORD_EN selects byte/half lanes with sign/zero extension.
module load_queue_unit #(
   parameter int unsigned DW        = 32,
   parameter int unsigned AW        = 32,
   parameter int unsigned TW        = 32,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned NUM_SLOTS = 8
) (
   input  logic                    CLK,
   input  logic                    Reset,
   input  logic                    In_Valid,
   output logic                    In_Ready,
   input  logic [AW-1:0]           In_A,
   input  logic [TW-1:0]           In_Dest,
   input  logic                    In_RegWrite,
   input  logic [1:0]              In_Size,
   input  logic                    In_Signed,
   output logic                    DataMem_Req,
   output logic [AW-1:0]           DataMem_RA,
   input  logic                    DataMem_Ack,
   input  logic [DW-1:0]           DataMem_RD,
   output logic                    CDB_Req,
   input  logic                    CDB_Grant,
   output logic [DW-1:0]           DataLoad,
   output logic [TW-1:0]           DestLoad,
   output logic                    RegWriteLoad,
   input  logic [NUM_SLOTS*TW-1:0] RTag,
   output logic [NUM_SLOTS*DW-1:0] RData,
   output logic [NUM_SLOTS-1:0]    RFlag
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef enum logic [1:0] {IDLE, REQ, WB} stateT;

   stateT            state;
   logic [PW-1:0]    headPtr;
   logic [PW-1:0]    tailPtr;
   logic [CW-1:0]    count;
   logic [CW-1:0]    countAfter;
   logic [AW-1:0]    addrMem [DEPTH];
   logic [TW-1:0]    destMem [DEPTH];
   logic [DEPTH-1:0] regWriteMem;
   logic [DW-1:0]    resData;
   logic [TW-1:0]    resDest;
   logic [DW-1:0]    loadValue;
   logic             push;
   logic             pop;

   assign In_Ready   = (count != CW'(DEPTH));
   assign push       = In_Valid && In_Ready;
   assign pop        = (state == REQ) && DataMem_Ack;
   assign countAfter = count + CW'(push) - CW'(pop);

`ifdef LOAD_SUBWORD_EN
   logic [1:0]       sizeMem [DEPTH];
   logic [DEPTH-1:0] signedMem;

   function automatic logic [DW-1:0] extractLane(input logic [DW-1:0] rd, input logic [1:0] lane,
                                                 input logic [1:0] size, input logic sgn);
      logic [7:0]  b;
      logic [15:0] h;
      b = rd[{lane, 3'b000} +: 8];
      h = rd[{lane[1], 4'b0000} +: 16];
      case (size)
         2'd0:    return sgn ? {{(DW-8){b[7]}}, b} : {{(DW-8){1'b0}}, b};
         2'd1:    return sgn ? {{(DW-16){h[15]}}, h} : {{(DW-16){1'b0}}, h};
         default: return rd;
      endcase
   endfunction

   always_ff @(posedge CLK) begin
      if (push) begin
         sizeMem[tailPtr]   <= In_Size;
         signedMem[tailPtr] <= In_Signed;
      end
   end

   assign loadValue = extractLane(DataMem_RD, addrMem[headPtr][1:0], sizeMem[headPtr], signedMem[headPtr]);
`else
   logic unusedSubword;
   assign unusedSubword = ^{In_Size, In_Signed};
   assign loadValue     = DataMem_RD;
`endif

   // Entry storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge CLK) begin
      if (push) begin
         addrMem[tailPtr]     <= In_A;
         destMem[tailPtr]     <= In_Dest;
         regWriteMem[tailPtr] <= In_RegWrite;
      end
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         headPtr <= '0;
         tailPtr <= '0;
         count   <= '0;
      end else begin
         if (push) tailPtr <= tailPtr + PW'(1);
         if (pop)  headPtr <= headPtr + PW'(1);
         count <= countAfter;
      end
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state   <= IDLE;
         resData <= '0;
         resDest <= '0;
      end else begin
         case (state)
            IDLE: if (count != '0) state <= REQ;
            REQ: begin
               if (DataMem_Ack) begin
                  resData <= loadValue;
                  resDest <= destMem[headPtr];
                  if (regWriteMem[headPtr]) state <= WB;
                  else                      state <= (countAfter != '0) ? REQ : IDLE;
               end
            end
            WB: if (CDB_Grant) state <= (count != '0) ? REQ : IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign DataMem_Req  = (state == REQ);
   assign DataMem_RA   = DataMem_Req ? addrMem[headPtr] : '0;
   assign CDB_Req      = (state == WB);
   assign RegWriteLoad = CDB_Req && CDB_Grant;
   assign DataLoad     = CDB_Req ? resData : '0;
   assign DestLoad     = CDB_Req ? resDest : '0;

   always_comb begin
      RFlag = '1;
      RData = '0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
         if ((RTag[i*TW +: TW] == DestLoad) && RegWriteLoad) begin
            RFlag[i]          = 1'b0;
            RData[i*DW +: DW] = DataLoad;
         end
      end
   end

endmodule

// File: tb/tb_load_queue_unit.sv
// Directed self-checking bench for load_queue_unit (default and LOAD_SUBWORD_EN builds).
module tb_load_queue_unit;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 32;
   localparam int unsigned TW = 32;
   localparam int unsigned NS = 8;

   logic           CLK = 1'b0;
   logic           Reset;
   logic           In_Valid;
   logic           In_Ready;
   logic [AW-1:0]  In_A;
   logic [TW-1:0]  In_Dest;
   logic           In_RegWrite;
   logic [1:0]     In_Size;
   logic           In_Signed;
   logic           DataMem_Req;
   logic [AW-1:0]  DataMem_RA;
   logic           DataMem_Ack;
   logic [DW-1:0]  DataMem_RD;
   logic           CDB_Req;
   logic           CDB_Grant;
   logic [DW-1:0]  DataLoad;
   logic [TW-1:0]  DestLoad;
   logic           RegWriteLoad;
   logic [NS*TW-1:0] RTag;
   logic [NS*DW-1:0] RData;
   logic [NS-1:0]  RFlag;

   int checks   = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   load_queue_unit #(.DW(DW), .AW(AW), .TW(TW), .DEPTH(4), .NUM_SLOTS(NS)) dut (
      .CLK(CLK), .Reset(Reset),
      .In_Valid(In_Valid), .In_Ready(In_Ready), .In_A(In_A), .In_Dest(In_Dest),
      .In_RegWrite(In_RegWrite), .In_Size(In_Size), .In_Signed(In_Signed),
      .DataMem_Req(DataMem_Req), .DataMem_RA(DataMem_RA), .DataMem_Ack(DataMem_Ack),
      .DataMem_RD(DataMem_RD), .CDB_Req(CDB_Req), .CDB_Grant(CDB_Grant),
      .DataLoad(DataLoad), .DestLoad(DestLoad), .RegWriteLoad(RegWriteLoad),
      .RTag(RTag), .RData(RData), .RFlag(RFlag)
   );

   task automatic checkEq(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic enq(input logic [AW-1:0] a, input logic [TW-1:0] d, input logic rw,
                      input logic [1:0] sz, input logic sg);
      In_A = a; In_Dest = d; In_RegWrite = rw; In_Size = sz; In_Signed = sg;
      In_Valid = 1'b1;
      step();
      In_Valid = 1'b0;
   endtask

   task automatic waitReq();
      for (int k = 0; k < 20 && !DataMem_Req; k++) step();
      checkEq("reqSeen", DataMem_Req, 1'b1);
   endtask

   task automatic serveLoad(input logic [AW-1:0] a, input logic [DW-1:0] rd, input logic [DW-1:0] expData,
                            input int ackDelay, input int grantDelay, input logic [TW-1:0] d, input logic rw);
      waitReq();
      checkEq("ra", DataMem_RA, a);
      for (int k = 0; k < ackDelay; k++) begin
         step();
         checkEq("reqHeld", DataMem_Req, 1'b1);
         checkEq("raHeld", DataMem_RA, a);
      end
      DataMem_Ack = 1'b1;
      DataMem_RD  = rd;
      step();
      DataMem_Ack = 1'b0;
      DataMem_RD  = '0;
      if (rw) begin
         checkEq("cdbReq", CDB_Req, 1'b1);
         for (int k = 0; k < grantDelay; k++) begin
            checkEq("noGrantRwl", RegWriteLoad, 1'b0);
            checkEq("noGrantFlag", RFlag, 8'hFF);
            step();
            checkEq("cdbReqHeld", CDB_Req, 1'b1);
            checkEq("dataHeld", DataLoad, expData);
         end
         CDB_Grant = 1'b1;
         #1;
         checkEq("rwl", RegWriteLoad, 1'b1);
         checkEq("destLoad", DestLoad, d);
         checkEq("dataLoad", DataLoad, expData);
         checkEq("flagNoHit", RFlag, 8'hFF);
         step();
         CDB_Grant = 1'b0;
      end else begin
         checkEq("noBcastReq", CDB_Req, 1'b0);
         checkEq("noBcastRwl", RegWriteLoad, 1'b0);
      end
   endtask

   initial begin
      Reset = 1'b0; In_Valid = 1'b0; In_A = '0; In_Dest = '0; In_RegWrite = 1'b0;
      In_Size = 2'd2; In_Signed = 1'b0; DataMem_Ack = 1'b0; DataMem_RD = '0; CDB_Grant = 1'b1;
      for (int i = 0; i < NS; i++) RTag[i*TW +: TW] = (i == 2 || i == 5) ? 32'd5 : 32'(100 + i);

      // Reset state
      #12;
      checkEq("rstReady", In_Ready, 1'b1);
      checkEq("rstReq", DataMem_Req, 1'b0);
      checkEq("rstRa", DataMem_RA, '0);
      checkEq("rstCdbReq", CDB_Req, 1'b0);
      checkEq("rstRwl", RegWriteLoad, 1'b0);
      checkEq("rstFlag", RFlag, 8'hFF);
      checkEq("rstRData", RData, '0);
      CDB_Grant = 1'b0;
      step();
      Reset = 1'b1;
      step();
      checkEq("relReq", DataMem_Req, 1'b0);

      // Minimum-latency load with two matching RS slots
      enq(32'h40, 32'd5, 1'b1, 2'd2, 1'b0);
      checkEq("idleReq", DataMem_Req, 1'b0);
      step();
      checkEq("minReq", DataMem_Req, 1'b1);
      checkEq("minRa", DataMem_RA, 32'h40);
      DataMem_Ack = 1'b1; DataMem_RD = 32'hDEADBEEF;
      step();
      DataMem_Ack = 1'b0; DataMem_RD = '0;
      checkEq("minCdbReq", CDB_Req, 1'b1);
      checkEq("minReqLow", DataMem_Req, 1'b0);
      CDB_Grant = 1'b1;
      #1;
      checkEq("minRwl", RegWriteLoad, 1'b1);
      checkEq("minDest", DestLoad, 32'd5);
      checkEq("minData", DataLoad, 32'hDEADBEEF);
      checkEq("minFlag", RFlag, 8'hDB);
      checkEq("slot2", RData[2*DW +: DW], 32'hDEADBEEF);
      checkEq("slot5", RData[5*DW +: DW], 32'hDEADBEEF);
      checkEq("slot0", RData[0 +: DW], '0);
      checkEq("slot7", RData[7*DW +: DW], '0);
      step();
      CDB_Grant = 1'b0;
      checkEq("postCdbReq", CDB_Req, 1'b0);
      checkEq("postRwl", RegWriteLoad, 1'b0);

      // Fill the queue, reject a fifth load, drain in order
      for (int i = 0; i < 4; i++) enq(32'h100 + 32'(4*i), 32'(10 + i), 1'b1, 2'd2, 1'b0);
      checkEq("fullReady", In_Ready, 1'b0);
      enq(32'h999, 32'd99, 1'b1, 2'd2, 1'b0);
      checkEq("fullStill", In_Ready, 1'b0);
      checkEq("fullReq", DataMem_Req, 1'b1);
      checkEq("fullRa", DataMem_RA, 32'h100);
      DataMem_Ack = 1'b1; DataMem_RD = 32'h11111111;
      step();
      DataMem_Ack = 1'b0;
      checkEq("popReady", In_Ready, 1'b1);
      CDB_Grant = 1'b1;
      #1;
      checkEq("fullDest0", DestLoad, 32'd10);
      checkEq("fullData0", DataLoad, 32'h11111111);
      step();
      CDB_Grant = 1'b0;
      for (int i = 1; i < 4; i++)
         serveLoad(32'h100 + 32'(4*i), 32'(i * 32'h01010101), 32'(i * 32'h01010101), 0, 0, 32'(10 + i), 1'b1);
      step();
      checkEq("noFifthReq", DataMem_Req, 1'b0);
      checkEq("emptyReady", In_Ready, 1'b1);

      // Delayed ack and withheld grant
      enq(32'h80, 32'd9, 1'b1, 2'd2, 1'b0);
      serveLoad(32'h80, 32'hCAFEF00D, 32'hCAFEF00D, 3, 2, 32'd9, 1'b1);

      // RegWrite=0 load gives no broadcast; next one does
      enq(32'h200, 32'd6, 1'b0, 2'd2, 1'b0);
      enq(32'h204, 32'd7, 1'b1, 2'd2, 1'b0);
      serveLoad(32'h200, 32'h0BADF00D, 32'h0BADF00D, 0, 0, 32'd6, 1'b0);
      serveLoad(32'h204, 32'h77777777, 32'h77777777, 0, 0, 32'd7, 1'b1);

      // FIFO order across pointer wrap
      for (int i = 0; i < 4; i++) enq(32'h300 + 32'(4*i), 32'(20 + i), 1'b1, 2'd2, 1'b0);
      for (int i = 0; i < 2; i++)
         serveLoad(32'h300 + 32'(4*i), 32'hA0 + 32'(i), 32'hA0 + 32'(i), 0, 0, 32'(20 + i), 1'b1);
      for (int i = 4; i < 6; i++) enq(32'h300 + 32'(4*i), 32'(20 + i), 1'b1, 2'd2, 1'b0);
      for (int i = 2; i < 6; i++)
         serveLoad(32'h300 + 32'(4*i), 32'hA0 + 32'(i), 32'hA0 + 32'(i), 1, 1, 32'(20 + i), 1'b1);

      // Reset while in WB
      enq(32'h400, 32'd30, 1'b1, 2'd2, 1'b0);
      enq(32'h404, 32'd31, 1'b1, 2'd2, 1'b0);
      waitReq();
      DataMem_Ack = 1'b1; DataMem_RD = 32'h55AA55AA;
      step();
      DataMem_Ack = 1'b0;
      checkEq("wbCdbReq", CDB_Req, 1'b1);
      CDB_Grant = 1'b1;
      Reset = 1'b0;
      #1;
      checkEq("rstWbCdbReq", CDB_Req, 1'b0);
      checkEq("rstWbRwl", RegWriteLoad, 1'b0);
      checkEq("rstWbData", DataLoad, '0);
      checkEq("rstWbFlag", RFlag, 8'hFF);
      checkEq("rstWbReady", In_Ready, 1'b1);
      CDB_Grant = 1'b0;
      step();
      Reset = 1'b1;
      step();
      checkEq("relEmptyReq", DataMem_Req, 1'b0);
      DataMem_Ack = 1'b1;
      step();
      DataMem_Ack = 1'b0;
      checkEq("lateAckCdb", CDB_Req, 1'b0);
      checkEq("lateAckReq", DataMem_Req, 1'b0);

      // Subword lanes (full word expected when the feature is off)
      enq(32'h43, 32'd40, 1'b1, 2'd0, 1'b1);
`ifdef LOAD_SUBWORD_EN
      serveLoad(32'h43, 32'h80FF1234, 32'hFFFFFF80, 0, 0, 32'd40, 1'b1);
`else
      serveLoad(32'h43, 32'h80FF1234, 32'h80FF1234, 0, 0, 32'd40, 1'b1);
`endif
      enq(32'h43, 32'd41, 1'b1, 2'd0, 1'b0);
`ifdef LOAD_SUBWORD_EN
      serveLoad(32'h43, 32'h80FF1234, 32'h00000080, 0, 0, 32'd41, 1'b1);
`else
      serveLoad(32'h43, 32'h80FF1234, 32'h80FF1234, 0, 0, 32'd41, 1'b1);
`endif
      enq(32'h42, 32'd42, 1'b1, 2'd1, 1'b1);
`ifdef LOAD_SUBWORD_EN
      serveLoad(32'h42, 32'h80FF1234, 32'hFFFF80FF, 0, 0, 32'd42, 1'b1);
`else
      serveLoad(32'h42, 32'h80FF1234, 32'h80FF1234, 0, 0, 32'd42, 1'b1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
